// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the CPU memory bus responder
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic [3:0] LDR = 4'b1101;
  localparam int BUS_W = 32;
  function automatic logic addr_err(logic [BUS_W-1:0] a, int aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != '0);
  endfunction
endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: memory controller to data memory request/acknowledge bus
interface mem_bus_if;
  import mem_bus_pkg::*;
  logic Req;
  logic RW;
  logic [BUS_W-1:0] AddressBus;
  logic [BUS_W-1:0] DataBusIn;
  logic [BUS_W-1:0] DataBusOut;
  logic Ack;
  logic Err;
  logic Busy;
  modport master(output Req, RW, AddressBus, DataBusIn, input DataBusOut, Ack, Err, Busy);
  modport slave(input Req, RW, AddressBus, DataBusIn, output DataBusOut, Ack, Err, Busy);
endinterface

// File: rtl/mem_word_array.sv
// mem_word_array: word storage with synchronous write and combinational read
module mem_word_array
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BUS_W-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BUS_W-1:0]      rdata
);
  logic [BUS_W-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: wait-stated load/store responder with address error checking
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_bus_if.slave   bus
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [BUS_W-1:0] a_addr, a_data, src_addr, rdata, dout;
  logic a_rw, src_rw, src_err, err_q, entry, we;
  always_comb begin
    src_addr = state == IDLE ? bus.AddressBus : a_addr;
    src_rw = state == IDLE ? bus.RW : a_rw;
    src_err = addr_err(src_addr, ADDR_WIDTH);
    nxt = state == IDLE ? (bus.Req ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE) :
          state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    entry = nxt == RESP && state != RESP;
    we = rst_n && state == RESP && a_rw == RW_WRITE && !addr_err(a_addr, ADDR_WIDTH);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      dout <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.Req) begin
        a_addr <= bus.AddressBus;
        a_rw <= bus.RW;
        a_data <= bus.DataBusIn;
        cnt <= 4'(WAIT_STATES - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      dout <= (entry && src_rw == RW_READ && !src_err) ? rdata : '0;
      err_q <= entry && src_err;
    end
  end
  mem_word_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(a_addr[ADDR_WIDTH+1:2]),
    .wdata(a_data),
    .raddr(src_addr[ADDR_WIDTH+1:2]),
    .rdata(rdata)
  );
  assign bus.DataBusOut = dout;
  assign bus.Err = err_q;
  assign bus.Ack = state == RESP;
  assign bus.Busy = state != IDLE;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of two responders (2 and 0 wait states) sharing one bus drive
module tb_mem_bus_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic Req, RW;
  logic [31:0] AddressBus, DataBusIn;
  int checks = 0;
  int errors = 0;
  logic [31:0] got_d;
  logic got_e;
  int lat;
  mem_bus_if b2();
  mem_bus_if b0();
  assign b2.Req = Req;
  assign b2.RW = RW;
  assign b2.AddressBus = AddressBus;
  assign b2.DataBusIn = DataBusIn;
  assign b0.Req = Req;
  assign b0.RW = RW;
  assign b0.AddressBus = AddressBus;
  assign b0.DataBusIn = DataBusIn;
  mem_bus_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mem_bus_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  always #5 clk = ~clk;
  function automatic logic ack_of(bit s);
    return s ? b0.Ack : b2.Ack;
  endfunction
  function automatic logic [31:0] dout_of(bit s);
    return s ? b0.DataBusOut : b2.DataBusOut;
  endfunction
  function automatic logic err_of(bit s);
    return s ? b0.Err : b2.Err;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic txn(input bit s, input logic rw, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    Req = 1'b1;
    RW = rw;
    AddressBus = addr;
    DataBusIn = data;
    @(posedge clk);
    #1;
    Req = 1'b0;
    RW = ~rw;
    AddressBus = 32'h0000_0040;
    DataBusIn = 32'h0;
    #1;
    lat = 1;
    while (!ack_of(s) && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    got_d = dout_of(s);
    got_e = err_of(s);
    @(posedge clk);
    #2;
    check("ack_one_cycle", 32'(ack_of(s)), 32'd0);
    check("dout_cleared", dout_of(s), 32'd0);
    repeat (3) @(posedge clk);
  endtask
  initial begin
    int t, a1, a2;
    rst_n = 1'b0;
    Req = 1'b0;
    RW = 1'b0;
    AddressBus = '0;
    DataBusIn = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ack", 32'(b2.Ack), 32'd0);
    check("rst_busy", 32'(b2.Busy), 32'd0);
    check("rst_err", 32'(b2.Err), 32'd0);
    check("rst_dout", b2.DataBusOut, 32'd0);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h0000_0010, 32'h9abc_def0);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_err", 32'(got_e), 32'd0);
    txn(0, 1'b1, 32'h0000_0010, 32'h0);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", got_d, 32'h9abc_def0);
    check("rd_err", 32'(got_e), 32'd0);
    txn(0, 1'b1, 32'h1234_5678, 32'h0);
    check("mis_rd_err", 32'(got_e), 32'd1);
    check("mis_rd_data", got_d, 32'd0);
    txn(0, 1'b0, 32'h0000_0011, 32'hffff_ffff);
    check("mis_wr_err", 32'(got_e), 32'd1);
    txn(0, 1'b1, 32'h0000_0010, 32'h0);
    check("mis_wr_kept", got_d, 32'h9abc_def0);
    txn(0, 1'b0, 32'h0000_0000, 32'h0000_0055);
    txn(0, 1'b0, 32'h0000_0400, 32'h0000_00aa);
    check("oor_err", 32'(got_e), 32'd1);
    txn(0, 1'b1, 32'h0000_0000, 32'h0);
    check("oor_kept", got_d, 32'h0000_0055);
    @(posedge clk);
    #1;
    Req = 1'b1;
    RW = 1'b0;
    AddressBus = 32'h0000_0020;
    DataBusIn = 32'h0000_0011;
    a1 = -1;
    a2 = -1;
    t = 0;
    while (a2 < 0 && t < 30) begin
      @(posedge clk);
      #1;
      t++;
      if (b2.Ack) begin
        if (a1 < 0) begin
          a1 = t;
          RW = 1'b1;
        end else begin
          a2 = t;
          Req = 1'b0;
          got_d = b2.DataBusOut;
          got_e = b2.Err;
        end
      end
    end
    check("b2b_first", 32'(a1), 32'd3);
    check("b2b_gap", 32'(a2 - a1), 32'd4);
    check("b2b_data", got_d, 32'h0000_0011);
    check("b2b_err", 32'(got_e), 32'd0);
    repeat (4) @(posedge clk);
    txn(0, 1'b0, 32'h0000_0030, 32'hcafe_0001);
    txn(1, 1'b1, 32'h0000_0030, 32'h0);
    check("w0_lat", 32'(lat), 32'd1);
    check("w0_data", got_d, 32'hcafe_0001);
    check("w0_err", 32'(got_e), 32'd0);
    txn(0, 1'b0, 32'h0000_0008, 32'h0000_0001);
    @(posedge clk);
    #1;
    Req = 1'b1;
    RW = 1'b0;
    AddressBus = 32'h0000_0008;
    DataBusIn = 32'hdead_beef;
    @(posedge clk);
    #1;
    Req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ack", 32'(b2.Ack), 32'd0);
    check("rst_mid_busy", 32'(b2.Busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    txn(0, 1'b1, 32'h0000_0008, 32'h0);
    check("rst_mid_kept", got_d, 32'h0000_0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
